// File: rtl/controler.sv
// Multicycle MIPS main controller: Moore FSM that sequences fetch, decode,
// execute and writeback for lw, sw, R-type, beq, addi and j. It also holds the
// combinational ALU decoder that turns aluop/funct into an ALU control code.
module controler (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [3:0] alucontrol
);

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] aluop;
   logic       pcwrite;
   logic       branch;

   // State register; reset abandons any in-flight instruction and returns to FETCH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state sequencing; decode dispatches on opcode, illegal opcodes drop back to FETCH.
   always_comb begin
      state_next = FETCH;
      case (state_reg)
         FETCH:   state_next = DECODE;
         DECODE: begin
            case (op)
               OP_LW,
               OP_SW:   state_next = MEMADR;
               OP_R:    state_next = RTYPEEX;
               OP_BEQ:  state_next = BEQEX;
               OP_ADDI: state_next = ADDIEX;
               OP_J:    state_next = JEX;
               default: state_next = FETCH;
            endcase
         end
         MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_next = MEMWB;
         MEMWB:   state_next = FETCH;
         MEMWR:   state_next = FETCH;
         RTYPEEX: state_next = RTYPEWB;
         RTYPEWB: state_next = FETCH;
         BEQEX:   state_next = FETCH;
         ADDIEX:  state_next = ADDIWB;
         ADDIWB:  state_next = FETCH;
         JEX:     state_next = FETCH;
         default: state_next = FETCH;
      endcase
   end

   // Moore control outputs decoded from the current state only.
   always_comb begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      case (state_reg)
         FETCH: begin
            alusrcb = 2'b01;
            irwrite = 1'b1;
            pcwrite = 1'b1;
         end
         DECODE: begin
            alusrcb = 2'b11;
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD: begin
            iord = 1'b1;
         end
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB: begin
            regwrite = 1'b1;
         end
         JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: begin
            aluop = 2'b00;
         end
      endcase
   end

   // PC enable: unconditional writes plus a taken branch when the ALU reports equality.
   always_comb begin
      pcen = pcwrite | (branch & zero);
   end

   // ALU decoder: fixed add/sub for aluop 00/01, funct-driven for R-type.
   always_comb begin
      alucontrol = 4'b0010;
      case (aluop)
         2'b00: alucontrol = 4'b0010;
         2'b01: alucontrol = 4'b0110;
         2'b10: begin
            case (funct)
               6'b100000: alucontrol = 4'b0010;
               6'b100010: alucontrol = 4'b0110;
               6'b100100: alucontrol = 4'b0000;
               6'b100101: alucontrol = 4'b0001;
               6'b101010: alucontrol = 4'b0111;
               default:   alucontrol = 4'b0010;
            endcase
         end
         default: alucontrol = 4'b0010;
      endcase
   end

endmodule

// File: tb/tb_controler.sv
// Scoreboard bench for the multicycle controller: each instruction pushes the
// expected per-cycle output vectors, which are popped and compared on negedges.
module tb_controler;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
   logic [1:0] alusrcb, pcsrc;
   logic [3:0] alucontrol;

   int n_vec;
   int n_err;
   logic [15:0] exp_q[$];

   // Reference state identifiers (bench-local numbering)
   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                  S_MEMWR = 5, S_REX = 6, S_RWB = 7, S_BEQ = 8, S_AEX = 9, S_AWB = 10,
                  S_JEX = 11;

   controler dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .iord       (iord),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] outs_now();
      return {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
              alusrcb, pcsrc, alucontrol};
   endfunction

   // Expected outputs per state, written from the control table
   function automatic logic [15:0] model(int s, logic [5:0] f, logic z);
      logic pe, mw, irw, rw, asa, io, m2r, rd;
      logic [1:0] asb, ps;
      logic [3:0] ac;
      pe = 0; mw = 0; irw = 0; rw = 0; asa = 0; io = 0; m2r = 0; rd = 0;
      asb = 2'b00; ps = 2'b00; ac = 4'b0010;
      case (s)
         S_FETCH:  begin pe = 1; irw = 1; asb = 2'b01; end
         S_DECODE: asb = 2'b11;
         S_MEMADR: begin asa = 1; asb = 2'b10; end
         S_MEMRD:  io = 1;
         S_MEMWB:  begin m2r = 1; rw = 1; end
         S_MEMWR:  begin io = 1; mw = 1; end
         S_REX: begin
            asa = 1;
            case (f)
               6'b100010: ac = 4'b0110;
               6'b100100: ac = 4'b0000;
               6'b100101: ac = 4'b0001;
               6'b101010: ac = 4'b0111;
               default:   ac = 4'b0010;
            endcase
         end
         S_RWB:    begin rd = 1; rw = 1; end
         S_BEQ:    begin asa = 1; ps = 2'b01; ac = 4'b0110; pe = z; end
         S_AEX:    begin asa = 1; asb = 2'b10; end
         S_AWB:    rw = 1;
         S_JEX:    begin ps = 2'b10; pe = 1; end
         default:  ac = 4'b0010;
      endcase
      return {pe, mw, irw, rw, asa, io, m2r, rd, asb, ps, ac};
   endfunction

   task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", tag, got, exp);
      end
   endtask

   // Pop one expectation and compare against the DUT outputs right now
   task automatic pop_check(input string tag);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         check_vec({tag, "_underflow"}, outs_now(), 16'hxxxx);
      end else begin
         e = exp_q.pop_front();
         check_vec(tag, outs_now(), e);
      end
   endtask

   // Runs one instruction starting in FETCH just before a rising edge; ends back in FETCH.
   task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                            input logic z);
      int seq[$];
      int cyc;
      op = o; funct = f; zero = z;
      seq.push_back(S_DECODE);
      case (o)
         6'b100011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
         6'b101011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWR); end
         6'b000000: begin seq.push_back(S_REX); seq.push_back(S_RWB); end
         6'b000100: seq.push_back(S_BEQ);
         6'b001000: begin seq.push_back(S_AEX); seq.push_back(S_AWB); end
         6'b000010: seq.push_back(S_JEX);
         default:   ;
      endcase
      seq.push_back(S_FETCH);
      foreach (seq[i]) exp_q.push_back(model(seq[i], f, z));
      cyc = seq.size();
      for (int i = 0; i < cyc; i++) begin
         @(negedge clk);
         pop_check($sformatf("%s_c%0d", tag, i + 2));
      end
      $display("instr %s op=%b funct=%b zero=%b cycles=%0d", tag, o, f, z, cyc + 1);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      op = 6'b0; funct = 6'b0; zero = 1'b0;
      reset = 1'b1;
      exp_q.push_back(model(S_FETCH, 6'b0, 1'b0));
      exp_q.push_back(model(S_FETCH, 6'b0, 1'b0));
      @(negedge clk); pop_check("reset_t10");
      @(negedge clk); pop_check("reset_t20");
      #2 reset = 1'b0;
      $display("reset released at t=%0t", $time);

      run_instr("lw",      6'b100011, 6'b000000, 1'b1);
      run_instr("sw",      6'b101011, 6'b101010, 1'b1);
      run_instr("sub",     6'b000000, 6'b100010, 1'b0);
      run_instr("slt",     6'b000000, 6'b101010, 1'b1);
      run_instr("and",     6'b000000, 6'b100100, 1'b0);
      run_instr("or",      6'b000000, 6'b100101, 1'b1);
      run_instr("add",     6'b000000, 6'b100000, 1'b0);
      run_instr("rother",  6'b000000, 6'b111111, 1'b1);
      run_instr("beq_t",   6'b000100, 6'b100101, 1'b1);
      run_instr("beq_nt",  6'b000100, 6'b100101, 1'b0);
      run_instr("addi",    6'b001000, 6'b100010, 1'b1);
      run_instr("j",       6'b000010, 6'b000000, 1'b0);
      run_instr("ill3f",   6'b111111, 6'b100010, 1'b1);
      run_instr("ill01",   6'b000001, 6'b000000, 1'b1);
      for (int k = 0; k < 4; k++) begin
         run_instr("rrand", 6'b000000, 6'($urandom_range(32, 42)), 1'($urandom_range(0, 1)));
      end

      // Reset asserted mid-lw (in MEMRD) must show FETCH outputs before the next edge
      op = 6'b100011; funct = 6'b0; zero = 1'b0;
      exp_q.push_back(model(S_DECODE, funct, zero));
      exp_q.push_back(model(S_MEMADR, funct, zero));
      exp_q.push_back(model(S_MEMRD, funct, zero));
      @(negedge clk); pop_check("rstmid_decode");
      @(negedge clk); pop_check("rstmid_memadr");
      @(negedge clk); pop_check("rstmid_memrd");
      #1 reset = 1'b1;
      #1;
      exp_q.push_back(model(S_FETCH, funct, zero));
      pop_check("rstmid_async");
      exp_q.push_back(model(S_FETCH, funct, zero));
      @(negedge clk); pop_check("rstmid_held");
      #2 reset = 1'b0;
      $display("instr lw_abort reset in MEMRD -> FETCH");
      run_instr("lw_after", 6'b100011, 6'b000000, 1'b0);

      if (exp_q.size() != 0) check_vec("queue_leftover", 16'(exp_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
